// File: rtl/prog_loader.sv
// Assembles big-endian byte pairs from uart_rx into instruction words and writes them to program memory from address 0.
// Holds the CPU off until a HALT word or the last address is written. Reloads on i_Start from DONE.
module prog_loader #(
   parameter int                NBITS_0     = 11,
   parameter int                NBITS_D     = 16,
   parameter int                OPCODE      = 5,
   parameter logic [OPCODE-1:0] HALT_OPCODE = 5'b00000,
   parameter int                TIMEOUT     = 100000
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic [7:0]         i_RxData,
   input  logic               i_RxDone,
   input  logic               i_Start,
   output logic               o_WrProg,
   output logic [NBITS_0-1:0] o_ProgAddr,
   output logic [NBITS_D-1:0] o_ProgData,
   output logic               o_CpuRun,
   output logic               o_Done,
   output logic               o_Timeout,
   output logic [NBITS_0:0]   o_Count
);

   localparam int            TW   = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

   typedef enum logic [1:0] {WAIT_HI, WAIT_LO, WRITE, DONE} state_t;

   state_t             r_state;
   logic [NBITS_0-1:0] r_addr;
   logic [NBITS_D-1:0] r_data;
   logic [NBITS_0:0]   r_count;
   logic [TW-1:0]      r_timer;
   logic               r_wr;
   logic               r_run;
   logic               r_done;
   logic               r_timeout;

   logic w_halt;
   logic w_last;

   assign w_halt = (r_data[NBITS_D-1 -: OPCODE] == HALT_OPCODE);
   assign w_last = (r_addr == {NBITS_0{1'b1}});

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_state   <= WAIT_HI;
         r_addr    <= '0;
         r_data    <= '0;
         r_count   <= '0;
         r_timer   <= '0;
         r_wr      <= 1'b0;
         r_run     <= 1'b0;
         r_done    <= 1'b0;
         r_timeout <= 1'b0;
      end else begin
         r_wr      <= 1'b0;
         r_timeout <= 1'b0;
         case (r_state)
            WAIT_HI: begin
               if (i_RxDone) begin
                  r_data[NBITS_D-1 -: 8] <= i_RxData;
                  r_timer                <= '0;
                  r_state                <= WAIT_LO;
               end
            end
            WAIT_LO: begin
               // A low byte arriving on the expiry cycle still completes the word.
               if (i_RxDone) begin
                  r_data[7:0] <= i_RxData;
                  r_wr        <= 1'b1;
                  r_state     <= WRITE;
               end else if (r_timer == TMAX) begin
                  r_timeout <= 1'b1;
                  r_state   <= WAIT_HI;
               end else begin
                  r_timer <= r_timer + 1'b1;
               end
            end
            WRITE: begin
               r_count <= r_count + 1'b1;
               if (w_halt || w_last) begin
                  r_run   <= 1'b1;
                  r_done  <= 1'b1;
                  r_state <= DONE;
               end else begin
                  r_addr <= r_addr + 1'b1;
                  // A byte landing in the write cycle is the next word's high byte.
                  if (i_RxDone) begin
                     r_data[NBITS_D-1 -: 8] <= i_RxData;
                     r_timer                <= '0;
                     r_state                <= WAIT_LO;
                  end else begin
                     r_state <= WAIT_HI;
                  end
               end
            end
            DONE: begin
               if (i_Start) begin
                  r_addr  <= '0;
                  r_count <= '0;
                  r_run   <= 1'b0;
                  r_done  <= 1'b0;
                  r_state <= WAIT_HI;
               end
            end
            default: r_state <= WAIT_HI;
         endcase
      end
   end

   assign o_WrProg   = r_wr;
   assign o_ProgAddr = r_addr;
   assign o_ProgData = r_data;
   assign o_CpuRun   = r_run;
   assign o_Done     = r_done;
   assign o_Timeout  = r_timeout;
   assign o_Count    = r_count;

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: word-level model of the loader plus literal spot checks.
module tb_prog_loader;
   localparam int NB = 3;
   localparam int TO = 16;

   logic          i_clk = 1'b0;
   logic          i_reset = 1'b0;
   logic [7:0]    i_RxData = 8'h00;
   logic          i_RxDone = 1'b0;
   logic          i_Start = 1'b0;
   logic          o_WrProg;
   logic [NB-1:0] o_ProgAddr;
   logic [15:0]   o_ProgData;
   logic          o_CpuRun;
   logic          o_Done;
   logic          o_Timeout;
   logic [NB:0]   o_Count;

   prog_loader #(.NBITS_0(NB), .NBITS_D(16), .OPCODE(5), .HALT_OPCODE(5'b00000), .TIMEOUT(TO)) dut (
      .i_clk(i_clk), .i_reset(i_reset), .i_RxData(i_RxData), .i_RxDone(i_RxDone), .i_Start(i_Start),
      .o_WrProg(o_WrProg), .o_ProgAddr(o_ProgAddr), .o_ProgData(o_ProgData), .o_CpuRun(o_CpuRun),
      .o_Done(o_Done), .o_Timeout(o_Timeout), .o_Count(o_Count));

   always #5 i_clk = ~i_clk;

   typedef struct {
      logic [NB-1:0] a;
      logic [15:0]   d;
   } wr_t;

   int total = 0;
   int bad = 0;
   wr_t exp_q[$];
   logic [NB-1:0] log_a[$];
   logic [15:0]   log_d[$];
   int to_seen = 0;
   int exp_to = 0;

   // Word-level model: pairs bytes, tracks address/count/done, discards stale halves.
   logic          m_pend = 1'b0;
   logic [7:0]    m_hi = 8'h00;
   int            m_idle = 0;
   logic [NB-1:0] m_addr = '0;
   int            m_cnt = 0;
   logic          m_done = 1'b0;

   task automatic model_clear();
      m_pend = 1'b0; m_idle = 0; m_addr = '0; m_cnt = 0; m_done = 1'b0;
   endtask

   task automatic model_byte(input logic [7:0] b);
      logic [15:0] w;
      if (m_done) return;
      if (!m_pend) begin
         m_hi = b; m_pend = 1'b1; m_idle = 0;
      end else begin
         w = {m_hi, b};
         exp_q.push_back('{a: m_addr, d: w});
         m_pend = 1'b0;
         m_cnt++;
         if (w[15:11] == 5'd0 || m_addr == {NB{1'b1}}) m_done = 1'b1;
         else m_addr = m_addr + 1'b1;
      end
   endtask

   task automatic model_idle();
      if (!m_done && m_pend) begin
         m_idle++;
         if (m_idle == TO) begin
            m_pend = 1'b0;
            exp_to++;
         end
      end
   endtask

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         model_idle();
         step();
      end
   endtask

   task automatic send(input logic [7:0] b, input int gap);
      i_RxData = b; i_RxDone = 1'b1;
      model_byte(b);
      step();
      i_RxDone = 1'b0;
      idle(gap);
   endtask

   task automatic start();
      i_Start = 1'b1;
      if (m_done) model_clear();
      step();
      i_Start = 1'b0;
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   task automatic chk_wr(input string name, input int idx, input logic [NB-1:0] a, input logic [15:0] d);
      if (idx >= log_d.size()) begin
         total++; bad++;
         $display("FAIL %s missing write #%0d (have %0d)", name, idx, log_d.size());
      end else begin
         chk({name, "_addr"}, 32'(log_a[idx]), 32'(a));
         chk({name, "_data"}, 32'(log_d[idx]), 32'(d));
      end
   endtask

   task automatic chk_settled(input string name);
      chk({name, "_pending"}, exp_q.size(), 0);
      chk({name, "_count"}, 32'(o_Count), 32'(m_cnt));
      chk({name, "_done"}, 32'(o_Done), 32'(m_done));
      chk({name, "_timeouts"}, to_seen, exp_to);
   endtask

   always @(negedge i_clk) begin
      if (i_reset) begin
         total++;
         if (o_Done !== o_CpuRun) begin
            bad++;
            $display("FAIL done_vs_run done=%b run=%b", o_Done, o_CpuRun);
         end
         if (o_Timeout === 1'b1) to_seen++;
         if (o_WrProg === 1'b1) begin
            log_a.push_back(o_ProgAddr);
            log_d.push_back(o_ProgData);
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL unexpected_write got addr=%0h data=%h exp none", o_ProgAddr, o_ProgData);
            end else begin
               wr_t e;
               e = exp_q.pop_front();
               if (e.a !== o_ProgAddr || e.d !== o_ProgData) begin
                  bad++;
                  $display("FAIL write got addr=%0h data=%h exp addr=%0h data=%h",
                           o_ProgAddr, o_ProgData, e.a, e.d);
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=running exp=finished");
      $display("test done: total=%0d bad=%0d", total, bad + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      // Reset state
      #12;
      chk("rst_wr", 32'(o_WrProg), 0);
      chk("rst_run", 32'(o_CpuRun), 0);
      chk("rst_done", 32'(o_Done), 0);
      chk("rst_count", 32'(o_Count), 0);
      chk("rst_data", 32'(o_ProgData), 0);
      @(negedge i_clk);
      i_reset = 1'b1;
      step();

      // Basic two-word load ending in HALT
      send(8'h08, 0); send(8'h05, 2); send(8'h00, 0); send(8'h00, 0);
      idle(4);
      chk_settled("t1");
      chk_wr("t1_w0", 0, 3'd0, 16'h0805);
      chk_wr("t1_w1", 1, 3'd1, 16'h0000);
      chk("t1_run", 32'(o_CpuRun), 1);
      chk("t1_count_lit", 32'(o_Count), 2);

      // Timeout discards a half word; one cycle short of the limit does not
      start();
      base = log_d.size();
      send(8'h08, TO + 4);
      chk("t2_to_lit", to_seen, 1);
      chk("t2_nowrite", log_d.size(), base);
      send(8'h10, TO - 1); send(8'h01, 1); send(8'h00, 0); send(8'h00, 3);
      chk_settled("t2");
      chk("t2_to_still1", to_seen, 1);
      chk_wr("t2_w0", base, 3'd0, 16'h1001);
      chk_wr("t2_w1", base + 1, 3'd1, 16'h0000);

      // Bytes ignored in DONE; reload via i_Start; i_Start mid-load ignored
      base = log_d.size();
      send(8'hAA, 0); send(8'hBB, 3);
      chk("t3_nowrite", log_d.size(), base);
      chk("t3_run_held", 32'(o_CpuRun), 1);
      start();
      chk("t3_run_drop", 32'(o_CpuRun), 0);
      chk("t3_count0", 32'(o_Count), 0);
      send(8'h12, 0); send(8'h34, 2);
      start();
      send(8'h00, 0); send(8'h00, 3);
      chk_settled("t3");
      chk_wr("t3_w0", base, 3'd0, 16'h1234);
      chk_wr("t3_w1", base + 1, 3'd1, 16'h0000);

      // Fill all 8 locations with non-HALT words: stops at last address
      start();
      base = log_d.size();
      for (int k = 1; k <= 8; k++) begin
         send(8'h08, 0); send(8'(k), 1);
      end
      idle(3);
      send(8'h09, 0); send(8'h09, 3);
      chk_settled("t4");
      chk("t4_nwr", log_d.size() - base, 8);
      chk_wr("t4_first", base, 3'd0, 16'h0801);
      chk_wr("t4_last", base + 7, 3'd7, 16'h0808);
      chk("t4_count_lit", 32'(o_Count), 8);

      // Byte in WRITE cycle becomes next high byte; dropped when WRITE goes to DONE
      start();
      base = log_d.size();
      send(8'h08, 0); send(8'h01, 0); send(8'h18, 0); send(8'h02, 3);
      send(8'h00, 0); send(8'h00, 0); send(8'hAA, 4);
      chk_settled("t5");
      chk_wr("t5_w0", base, 3'd0, 16'h0801);
      chk_wr("t5_w1", base + 1, 3'd1, 16'h1802);
      chk_wr("t5_w2", base + 2, 3'd2, 16'h0000);
      chk("t5_nwr", log_d.size() - base, 3);
      start();
      send(8'h0C, 0); send(8'h0D, 3);
      chk_wr("t5_reload", base + 3, 3'd0, 16'h0C0D);
      send(8'h00, 0); send(8'h00, 3);

      // Asynchronous reset in WAIT_LO after three words
      start();
      send(8'h08, 0); send(8'h01, 1); send(8'h08, 0); send(8'h02, 1);
      send(8'h08, 0); send(8'h03, 1); send(8'h09, 2);
      chk("t6_count_pre", 32'(o_Count), 3);
      #3;
      i_reset = 1'b0;
      #1;
      chk("t6_wr", 32'(o_WrProg), 0);
      chk("t6_addr", 32'(o_ProgAddr), 0);
      chk("t6_data", 32'(o_ProgData), 0);
      chk("t6_run", 32'(o_CpuRun), 0);
      chk("t6_done", 32'(o_Done), 0);
      chk("t6_to", 32'(o_Timeout), 0);
      chk("t6_count", 32'(o_Count), 0);
      chk("t6_pending", exp_q.size(), 0);
      model_clear();
      exp_q.delete();
      @(negedge i_clk);
      i_reset = 1'b1;
      step();
      base = log_d.size();
      send(8'h0F, 0); send(8'hFF, 2); send(8'h00, 0); send(8'h00, 3);
      chk_settled("t6");
      chk_wr("t6_w0", base, 3'd0, 16'h0FFF);
      chk_wr("t6_w1", base + 1, 3'd1, 16'h0000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Writer side of the program-memory interface: receives a program as a byte stream from the UART receiver, assembles 16-bit instruction words, and writes them sequentially into program memory from address 0.
- The control unit only reads program memory (PC-addressed fetch). This block keeps the CPU held off (o_CpuRun=0) until the program is fully written, then releases it.
- Sits between uart_rx and the program memory write port; o_CpuRun feeds the CPU's run/reset gating.

Parameters:
NBITS_0, 11, program memory address width
NBITS_D, 16, instruction width; fixed at 2 bytes per word
OPCODE, 5, opcode field width (instruction MSBs)
HALT_OPCODE, 5'b00000, opcode that terminates the load
TIMEOUT, 100000, maximum clock cycles allowed between the high and low byte of one word

Ports:
i_clk  in  1  clock, rising edge
i_reset  in  1  reset, asynchronous, active-low (0 = reset)
i_RxData  in  8  received byte, valid when i_RxDone=1
i_RxDone  in  1  single-cycle byte-valid strobe from uart_rx
i_Start  in  1  single-cycle request to reload the program; honoured only in DONE
o_WrProg  out  1  program memory write enable, one-cycle pulse
o_ProgAddr  out  NBITS_0  program memory write address
o_ProgData  out  NBITS_D  program memory write data
o_CpuRun  out  1  1 = program loaded, CPU may run
o_Done  out  1  high while in DONE
o_Timeout  out  1  one-cycle pulse when a partial word is discarded
o_Count  out  NBITS_0+1  number of words written in the current load

Behaviour:
- All outputs are registered.
- Reset (i_reset=0, asynchronous): state WAIT_HI; address=0; data=0; counter=0; timer=0; o_WrProg=0, o_CpuRun=0, o_Done=0, o_Timeout=0, o_Count=0. Reset mid-load discards everything and restarts from address 0.
- FSM states: WAIT_HI, WAIT_LO, WRITE, DONE.
- WAIT_HI:
  - On i_RxDone: data[15:8]<=i_RxData; timer<=0; go to WAIT_LO.
  - Otherwise hold.
- WAIT_LO:
  - Timer increments each cycle with no i_RxDone.
  - On i_RxDone: data[7:0]<=i_RxData; go to WRITE.
  - If timer reaches TIMEOUT-1 with no byte: discard the partial word, pulse o_Timeout next cycle, go to WAIT_HI. Address and o_Count are unchanged.
  - A byte arriving in that same cycle wins over the timeout.
- WRITE (exactly 1 cycle):
  - o_WrProg=1 with o_ProgAddr/o_ProgData stable that cycle; o_Count increments.
  - If data[15:11]==HALT_OPCODE or address==2^NBITS_0-1: go to DONE. Address does not advance.
  - Otherwise: address+1, go to WAIT_HI.
  - An i_RxDone in the WRITE cycle is captured as the next high byte (data[15:8]). The FSM then goes to WAIT_LO, not WAIT_HI. This does not apply if WRITE is going to DONE, where the byte is dropped.
- Latency: o_WrProg asserts on the clock edge following the cycle in which the low byte's i_RxDone is sampled.
- DONE:
  - o_CpuRun=1, o_Done=1; i_RxDone is ignored.
  - On i_Start: address=0, o_Count=0; go to WAIT_HI. o_CpuRun and o_Done drop on the next edge.
  - i_Start outside DONE has no effect.
- Write-data rule: o_ProgData changes only on byte capture and is never written without a completed pair.
- Address rule: address never wraps. The last location terminates the load even if it is not HALT.

Test Plan:
- Release reset, send bytes 0x08,0x05 then 0x00,0x00 -> two o_WrProg pulses: addr 0 data 0x0805, addr 1 data 0x0000; then o_Done=1, o_CpuRun=1, o_Count=2.
- Send 0x08 then nothing for TIMEOUT cycles (TIMEOUT=16 in bench) -> one o_Timeout pulse, no write. Then send 0x10,0x01,0x00,0x00 -> writes 0x1001 at addr 0 and HALT at addr 1.
- In DONE, send 0xAA,0xBB -> no write, o_CpuRun stays 1. Pulse i_Start -> o_CpuRun=0 next cycle; next pair writes at addr 0, o_Count restarts from 0.
- With NBITS_0=3, send 8 non-HALT words (0x0801..0x0808) -> writes to addr 0..7, DONE after the addr-7 write, no wrap to 0.
- Assert i_RxDone (0x18) in the WRITE cycle of word 0x0801, then send 0x02 -> addr 0=0x0801, addr 1=0x1802, with no byte lost.
- Pull i_reset low asynchronously during WAIT_LO after 3 words -> all outputs 0 immediately; a subsequent load writes from addr 0.
